row_normalizer: RTL

//  Gaussian-elimination front end to the combinational divider. Captures one

---
 rtl/linalg_pkg.sv | 15 +
 rtl/row_normalizer_division.sv | 29 ++
 rtl/row_normalizer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/linalg_pkg.sv
// Shared linear-algebra definitions: word width, divide-by-zero quotient and
// the row normaliser state encoding.
package linalg_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    DRAIN
  } rn_state_t;

endpackage

// File: rtl/row_normalizer_division.sv
// Combinational unsigned divider: Res = A/B rounded to nearest, ties away
// from zero. B == 0 yields all ones.
module division
  import linalg_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic [WORD_W-1:0] Res
);

  logic [WORD_W-1:0] quo;
  logic [WORD_W-1:0] rem;
  logic [WORD_W:0]   rem2;

  always_comb begin
    quo  = '0;
    rem  = '0;
    rem2 = '0;
    Res  = '1;
    if (B != '0) begin
      quo  = A / B;
      rem  = A % B;
      rem2 = {rem, 1'b0};
      // Round up when the remainder is at least half the divisor.
      Res  = (rem2 >= {1'b0, B}) ? quo + WORD_W'(1) : quo;
    end
  end

endmodule

// File: rtl/row_normalizer.sv
// Captures a row of N words plus a pivot, divides each word by the pivot one
// per cycle, then streams the quotients out over a valid/ready handshake.
module row_normalizer
  import linalg_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] pivot,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         div_zero
);

  localparam int unsigned     IW       = $clog2(N);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

  rn_state_t     state;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt_idx;
  logic [W-1:0]  pivot_q;
  logic [W-1:0]  row_buf [N];
  logic [W-1:0]  quo_buf [N];
  logic [W-1:0]  div_res;

  division u_division (
    .A   (row_buf[idx]),
    .B   (pivot_q),
    .Res (div_res)
  );

  always_comb begin
    nxt_idx = idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pivot_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            pivot_q  <= pivot;
            div_zero <= (pivot == '0);
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            if (idx == LAST_IDX) begin
              state    <= DIV;
              idx      <= '0;
              in_ready <= 1'b0;
            end else begin
              idx <= nxt_idx;
            end
          end
        end
        DIV: begin
          if (idx == LAST_IDX) begin
            // quo_buf[0] was written N-1 cycles ago, so it is safe to present now.
            state     <= DRAIN;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= quo_buf[0];
            out_last  <= 1'b0;
          end else begin
            idx <= nxt_idx;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state     <= IDLE;
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              idx      <= nxt_idx;
              out_data <= quo_buf[nxt_idx];
              out_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Data buffers carry no reset; their contents are only read after being written.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      row_buf[idx] <= in_data;
    end
    if (state == DIV) begin
      quo_buf[idx] <= div_zero ? DIV_BY_ZERO_Q : div_res;
    end
  end

endmodule
